// File: rtl/conv2_layer_sequencer_pkg.sv
// Shared types and helpers for the layer-2 conv sequencer.
// State encoding and a width helper used for port sizing.
package conv2_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_GAP,
    S_DONE
  } seq_state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/conv2_layer_sequencer_counter.sv
// Up-counter with sync clear (priority), enable and
// terminal-count flag at MAX.
module seq_beat_counter #(
  parameter int W   = 8,
  parameter int MAX = 143
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == W'(MAX));

endmodule

// File: rtl/conv2_layer_sequencer.sv
// Layer-2 conv sequencer: loads CI ifmap banks from the
// layer-1 stream, then runs CO read/convolve passes.
module conv2_layer_sequencer
  import conv2_layer_sequencer_pkg::*;
#(
  parameter int I_SIZE  = 12,
  parameter int CI      = 4,
  parameter int CO      = 12,
  parameter int ADDR_BW = 8,
  parameter int GAP_CYC = 2
) (
  input  logic                 clk,
  input  logic                 global_rst_n,
  input  logic                 user_reset,
  input  logic                 i_start,
  input  logic                 i_fmap_valid,
  input  logic                 i_fmap_ch_end,
  output logic                 o_fmap_ready,
  output logic [CI-1:0]        o_wr_en,
  output logic [ADDR_BW-1:0]   o_wr_addr,
  output logic                 o_rd_start,
  output logic [clog2(CO)-1:0] o_co_idx,
  input  logic                 i_conv_ch_end,
  output logic                 o_busy,
  output logic                 o_layer_done,
  output logic                 o_err
);

  localparam int BEATS   = I_SIZE * I_SIZE;
  localparam int CO_W    = clog2(CO);
  localparam int BK_W    = clog2(CI);
  localparam int GAP_W   = clog2(GAP_CYC + 1);
  localparam int GAP_MAX = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  seq_state_e state_q, state_d;
  logic [BK_W-1:0] bank_q, bank_d;
  logic [CO_W-1:0] co_q, co_d;
  logic ready_q, ready_d;
  logic rd_start_q, rd_start_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic accept;
  logic ch_last;
  logic addr_tc;
  logic gap_tc;
  logic in_gap;
  logic bank_last;
  logic co_last;
  logic [ADDR_BW-1:0] addr_cnt;
  logic [GAP_W-1:0] gap_cnt_unused;
  logic [CI-1:0] sel;

  assign accept    = i_fmap_valid & ready_q;
  assign ch_last   = i_fmap_ch_end | addr_tc;
  assign in_gap    = (state_q == S_GAP);
  assign bank_last = (bank_q == BK_W'(CI - 1));
  assign co_last   = (co_q == CO_W'(CO - 1));

  seq_beat_counter #(
    .W   (ADDR_BW),
    .MAX (BEATS - 1)
  ) u_addr_cnt (
    .clk   (clk),
    .rst_n (global_rst_n),
    .clr   (user_reset | (accept & ch_last)),
    .en    (accept),
    .cnt   (addr_cnt),
    .tc    (addr_tc)
  );

  seq_beat_counter #(
    .W   (GAP_W),
    .MAX (GAP_MAX)
  ) u_gap_cnt (
    .clk   (clk),
    .rst_n (global_rst_n),
    .clr   (user_reset | ~in_gap | gap_tc),
    .en    (in_gap),
    .cnt   (gap_cnt_unused),
    .tc    (gap_tc)
  );

  // next-state, pointers, sticky error, registered outputs
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    co_d    = co_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (i_fmap_ch_end != addr_tc) err_d = 1'b1;
          if (ch_last) begin
            if (bank_last) begin
              bank_d  = '0;
              state_d = S_START;
            end else begin
              bank_d = bank_q + 1'b1;
            end
          end
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (i_conv_ch_end) begin
          if (co_last) begin
            state_d = S_DONE;
          end else begin
            co_d    = co_q + 1'b1;
            state_d = (GAP_CYC == 0) ? S_START : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_tc) state_d = S_START;
      end
      S_DONE: begin
        co_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_conv_ch_end && (state_q != S_RUN)) err_d = 1'b1;
    if (user_reset) begin
      state_d = S_IDLE;
      bank_d  = '0;
      co_d    = '0;
      err_d   = 1'b0;
    end
    ready_d    = (state_d == S_LOAD);
    rd_start_d = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q    <= S_IDLE;
      bank_q     <= '0;
      co_q       <= '0;
      ready_q    <= 1'b0;
      rd_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      co_q       <= co_d;
      ready_q    <= ready_d;
      rd_start_q <= rd_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sel          = CI'(1) << bank_q;
  assign o_wr_en      = sel & {CI{accept}};
  assign o_wr_addr    = addr_cnt;
  assign o_fmap_ready = ready_q;
  assign o_rd_start   = rd_start_q;
  assign o_co_idx     = co_q;
  assign o_busy       = busy_q;
  assign o_layer_done = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_conv2_layer_sequencer.sv
// Directed bench for conv2_layer_sequencer: load, passes,
// bubbles, protocol errors, user_reset, stray events.
module tb_conv2_layer_sequencer;

  localparam int BEATS = 144;
  localparam int CI    = 4;
  localparam int CO    = 12;
  localparam int GAP   = 2;

  logic       clk;
  logic       global_rst_n;
  logic       user_reset;
  logic       i_start;
  logic       i_fmap_valid;
  logic       i_fmap_ch_end;
  logic       o_fmap_ready;
  logic [3:0] o_wr_en;
  logic [7:0] o_wr_addr;
  logic       o_rd_start;
  logic [3:0] o_co_idx;
  logic       i_conv_ch_end;
  logic       o_busy;
  logic       o_layer_done;
  logic       o_err;

  int checks;
  int errors;

  typedef struct {
    int         wait_cyc;
    logic [3:0] exp_co;
  } pass_t;

  pass_t passes [12];

  conv2_layer_sequencer dut (
    .clk           (clk),
    .global_rst_n  (global_rst_n),
    .user_reset    (user_reset),
    .i_start       (i_start),
    .i_fmap_valid  (i_fmap_valid),
    .i_fmap_ch_end (i_fmap_ch_end),
    .o_fmap_ready  (o_fmap_ready),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .o_rd_start    (o_rd_start),
    .o_co_idx      (o_co_idx),
    .i_conv_ch_end (i_conv_ch_end),
    .o_busy        (o_busy),
    .o_layer_done  (o_layer_done),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ch(input int bank, input int n,
                         input int end_at, input bit bub);
    logic [3:0] exp_en;
    exp_en = 4'b0001 << bank;
    for (int i = 0; i < n; i++) begin
      if (bub && ($urandom_range(0, 3) == 0)) begin
        i_fmap_valid  = 1'b0;
        i_fmap_ch_end = 1'b0;
        #1;
        chk("bubble_no_wr", {28'd0, o_wr_en}, 0);
        tick();
      end
      i_fmap_valid  = 1'b1;
      i_fmap_ch_end = (i == end_at);
      #1;
      chk("wr_en", {28'd0, o_wr_en}, {28'd0, exp_en});
      chk("wr_addr", {24'd0, o_wr_addr}, i);
      tick();
    end
    i_fmap_valid  = 1'b0;
    i_fmap_ch_end = 1'b0;
  endtask

  task automatic do_passes(input int stop_at);
    for (int p = 0; p < CO; p++) begin
      chk("rd_start", {31'd0, o_rd_start}, 1);
      tick();
      chk("rd_start_pulse", {31'd0, o_rd_start}, 0);
      chk("co_idx", {28'd0, o_co_idx},
          {28'd0, passes[p].exp_co});
      if (p == stop_at) return;
      repeat (passes[p].wait_cyc) tick();
      i_conv_ch_end = 1'b1;
      tick();
      i_conv_ch_end = 1'b0;
      if (p < CO - 1) begin
        for (int g = 0; g < GAP; g++) begin
          chk("gap_no_start", {31'd0, o_rd_start}, 0);
          tick();
        end
      end else begin
        chk("layer_done", {31'd0, o_layer_done}, 1);
        tick();
        chk("done_pulse", {31'd0, o_layer_done}, 0);
        chk("idle_busy", {31'd0, o_busy}, 0);
        chk("co_cleared", {28'd0, o_co_idx}, 0);
      end
    end
  endtask

  task automatic clean_layer();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("ready_after_start", {31'd0, o_fmap_ready}, 1);
    chk("busy_after_start", {31'd0, o_busy}, 1);
    chk("err_after_start", {31'd0, o_err}, 0);
    for (int b = 0; b < CI; b++) load_ch(b, BEATS, BEATS - 1, 0);
    chk("first_rd_start", {31'd0, o_rd_start}, 1);
    chk("ready_dropped", {31'd0, o_fmap_ready}, 0);
    chk("load_err", {31'd0, o_err}, 0);
    i_fmap_valid = 1'b1;
    #1;
    chk("no_wr_after_load", {28'd0, o_wr_en}, 0);
    i_fmap_valid = 1'b0;
    do_passes(CO);
    chk("clean_err", {31'd0, o_err}, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, o_busy}, 0);
    chk({tag, "_ready"}, {31'd0, o_fmap_ready}, 0);
    chk({tag, "_rd_start"}, {31'd0, o_rd_start}, 0);
    chk({tag, "_co"}, {28'd0, o_co_idx}, 0);
    chk({tag, "_done"}, {31'd0, o_layer_done}, 0);
    chk({tag, "_err"}, {31'd0, o_err}, 0);
    chk({tag, "_addr"}, {24'd0, o_wr_addr}, 0);
    i_fmap_valid = 1'b1;
    #1;
    chk({tag, "_wr_en"}, {28'd0, o_wr_en}, 0);
    i_fmap_valid = 1'b0;
  endtask

  initial begin
    passes = '{
      '{0, 4'd0}, '{1, 4'd1}, '{2, 4'd2}, '{3, 4'd3},
      '{0, 4'd4}, '{5, 4'd5}, '{1, 4'd6}, '{0, 4'd7},
      '{2, 4'd8}, '{4, 4'd9}, '{0, 4'd10}, '{3, 4'd11}
    };
    checks        = 0;
    errors        = 0;
    global_rst_n  = 1'b0;
    user_reset    = 1'b0;
    i_start       = 1'b0;
    i_fmap_valid  = 1'b0;
    i_fmap_ch_end = 1'b0;
    i_conv_ch_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    global_rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {31'd0, o_busy}, 0);

    clean_layer();

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    load_ch(0, BEATS, BEATS - 1, 1);
    chk("bubble_err", {31'd0, o_err}, 0);
    load_ch(1, 101, 100, 0);
    chk("early_end_err", {31'd0, o_err}, 1);
    load_ch(2, BEATS, BEATS - 1, 0);
    load_ch(3, BEATS, -1, 0);
    chk("forced_wrap_start", {31'd0, o_rd_start}, 1);
    chk("forced_wrap_err", {31'd0, o_err}, 1);
    do_passes(5);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    chk_all_zero("ureset");
    tick();
    chk("ureset_stays_idle", {31'd0, o_busy}, 0);

    clean_layer();

    i_start = 1'b1;
    tick();
    chk("stray_start_busy", {31'd0, o_busy}, 1);
    tick();
    i_start = 1'b0;
    chk("start_ignored_ready", {31'd0, o_fmap_ready}, 1);
    chk("start_ignored_err", {31'd0, o_err}, 0);
    chk("start_ignored_addr", {24'd0, o_wr_addr}, 0);
    i_conv_ch_end = 1'b1;
    tick();
    i_conv_ch_end = 1'b0;
    chk("stray_conv_err", {31'd0, o_err}, 1);
    chk("stray_conv_ready", {31'd0, o_fmap_ready}, 1);
    chk("stray_conv_rd", {31'd0, o_rd_start}, 0);
    for (int b = 0; b < CI; b++) load_ch(b, BEATS, BEATS - 1, 0);
    do_passes(CO);
    chk("err_sticky", {31'd0, o_err}, 1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_clears_err", {31'd0, o_err}, 0);
    chk("restart_busy", {31'd0, o_busy}, 1);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    chk("final_idle", {31'd0, o_busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
